// File: rtl/w_channel_router.sv
// AXI write-data stage: routes W beats from 3 masters to 7 slaves in per-slave
// AW-acceptance order, counts beats and generates WLAST toward each slave.
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

// state | meaning
// IDLE  | no outstanding write; accepts aw_hs
// PEND  | route queued, waiting to reach the head of the slave queue
// DATA  | owns the target slave, beats pass through
module w_channel_router #(
  parameter int NUM_M  = 3,
  parameter int NUM_S  = 7,
  parameter int QDEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_M-1:0]            aw_hs,
  input  logic [3*NUM_M-1:0]          aw_sel,
  input  logic [`AXI_LEN_BITS*NUM_M-1:0] aw_len,
  input  logic [`AXI_DATA_BITS-1:0]   WDATA_M0,
  input  logic [`AXI_STRB_BITS-1:0]   WSTRB_M0,
  input  logic                        WLAST_M0,
  input  logic                        WVALID_M0,
  output logic                        WREADY_M0,
  input  logic [`AXI_DATA_BITS-1:0]   WDATA_M1,
  input  logic [`AXI_STRB_BITS-1:0]   WSTRB_M1,
  input  logic                        WLAST_M1,
  input  logic                        WVALID_M1,
  output logic                        WREADY_M1,
  input  logic [`AXI_DATA_BITS-1:0]   WDATA_M2,
  input  logic [`AXI_STRB_BITS-1:0]   WSTRB_M2,
  input  logic                        WLAST_M2,
  input  logic                        WVALID_M2,
  output logic                        WREADY_M2,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_SD,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_SD,
  output logic                        WLAST_SD,
  output logic                        WVALID_SD,
  input  logic                        WREADY_SD,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_S0,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_S0,
  output logic                        WLAST_S0,
  output logic                        WVALID_S0,
  input  logic                        WREADY_S0,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_S1,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_S1,
  output logic                        WLAST_S1,
  output logic                        WVALID_S1,
  input  logic                        WREADY_S1,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_S2,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_S2,
  output logic                        WLAST_S2,
  output logic                        WVALID_S2,
  input  logic                        WREADY_S2,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_S3,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_S3,
  output logic                        WLAST_S3,
  output logic                        WVALID_S3,
  input  logic                        WREADY_S3,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_S4,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_S4,
  output logic                        WLAST_S4,
  output logic                        WVALID_S4,
  input  logic                        WREADY_S4,
  output logic [`AXI_DATA_BITS-1:0]   WDATA_S5,
  output logic [`AXI_STRB_BITS-1:0]   WSTRB_S5,
  output logic                        WLAST_S5,
  output logic                        WVALID_S5,
  input  logic                        WREADY_S5,
  output logic [NUM_M-1:0]            aw_block,
  output logic [NUM_M-1:0]            wlast_err
);

  localparam int DW = `AXI_DATA_BITS;
  localparam int SW = `AXI_STRB_BITS;
  localparam int LW = `AXI_LEN_BITS;
  localparam int QW = $clog2(QDEPTH + 1);
  localparam logic [QW-1:0] QFULL = QW'(QDEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} state_e;

  state_e          state_q [NUM_M];
  state_e          state_d [NUM_M];
  logic [2:0]      sel_q   [NUM_M];
  logic [2:0]      sel_d   [NUM_M];
  logic [LW-1:0]   len_q   [NUM_M];
  logic [LW-1:0]   len_d   [NUM_M];
  logic [LW-1:0]   cnt_q   [NUM_M];
  logic [LW-1:0]   cnt_d   [NUM_M];
  logic [NUM_M-1:0] wlast_err_q, wlast_err_d;

  logic [1:0]      qmem_q  [NUM_S][QDEPTH];
  logic [1:0]      qmem_d  [NUM_S][QDEPTH];
  logic [QW-1:0]   qcnt_q  [NUM_S];
  logic [QW-1:0]   qcnt_d  [NUM_S];
  logic            q_overflow;

  logic [DW-1:0]   m_wdata [NUM_M];
  logic [SW-1:0]   m_wstrb [NUM_M];
  logic [NUM_M-1:0] m_wvalid, m_wlast, m_wready;
  logic [NUM_M-1:0] at_last, beat, last_beat, push, head_match;

  logic [DW-1:0]   s_wdata [NUM_S];
  logic [SW-1:0]   s_wstrb [NUM_S];
  logic [NUM_S-1:0] s_wvalid, s_wlast, s_wready;

  assign m_wdata[0] = WDATA_M0;
  assign m_wdata[1] = WDATA_M1;
  assign m_wdata[2] = WDATA_M2;
  assign m_wstrb[0] = WSTRB_M0;
  assign m_wstrb[1] = WSTRB_M1;
  assign m_wstrb[2] = WSTRB_M2;
  assign m_wvalid   = {WVALID_M2, WVALID_M1, WVALID_M0};
  assign m_wlast    = {WLAST_M2, WLAST_M1, WLAST_M0};
  assign {WREADY_M2, WREADY_M1, WREADY_M0} = m_wready;

  assign s_wready = {WREADY_S5, WREADY_S4, WREADY_S3, WREADY_S2,
                     WREADY_S1, WREADY_S0, WREADY_SD};

  assign WDATA_SD  = s_wdata[0];
  assign WSTRB_SD  = s_wstrb[0];
  assign WLAST_SD  = s_wlast[0];
  assign WVALID_SD = s_wvalid[0];
  assign WDATA_S0  = s_wdata[1];
  assign WSTRB_S0  = s_wstrb[1];
  assign WLAST_S0  = s_wlast[1];
  assign WVALID_S0 = s_wvalid[1];
  assign WDATA_S1  = s_wdata[2];
  assign WSTRB_S1  = s_wstrb[2];
  assign WLAST_S1  = s_wlast[2];
  assign WVALID_S1 = s_wvalid[2];
  assign WDATA_S2  = s_wdata[3];
  assign WSTRB_S2  = s_wstrb[3];
  assign WLAST_S2  = s_wlast[3];
  assign WVALID_S2 = s_wvalid[3];
  assign WDATA_S3  = s_wdata[4];
  assign WSTRB_S3  = s_wstrb[4];
  assign WLAST_S3  = s_wlast[4];
  assign WVALID_S3 = s_wvalid[4];
  assign WDATA_S4  = s_wdata[5];
  assign WSTRB_S4  = s_wstrb[5];
  assign WLAST_S4  = s_wlast[5];
  assign WVALID_S4 = s_wvalid[5];
  assign WDATA_S5  = s_wdata[6];
  assign WSTRB_S5  = s_wstrb[6];
  assign WLAST_S5  = s_wlast[6];
  assign WVALID_S5 = s_wvalid[6];

  assign wlast_err = wlast_err_q;

  // Crossbar: at most one DATA owner per slave, guaranteed by the queue head.
  always_comb begin
    m_wready = '0;
    s_wvalid = '0;
    s_wlast  = '0;
    for (int s = 0; s < NUM_S; s++) begin
      s_wdata[s] = '0;
      s_wstrb[s] = '0;
    end
    for (int m = 0; m < NUM_M; m++) begin
      at_last[m] = (cnt_q[m] == len_q[m]);
      if (state_q[m] == ST_DATA) begin
        for (int s = 0; s < NUM_S; s++) begin
          if (sel_q[m] == 3'(s)) begin
            s_wvalid[s] = m_wvalid[m];
            s_wdata[s]  = m_wdata[m];
            s_wstrb[s]  = m_wstrb[m];
            s_wlast[s]  = at_last[m];
            m_wready[m] = s_wready[s];
          end
        end
      end
    end
    beat      = m_wvalid & m_wready;
    last_beat = beat & at_last;
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      head_match[m] = 1'b0;
      for (int s = 0; s < NUM_S; s++) begin
        if (sel_q[m] == 3'(s) && qcnt_q[s] != '0 && qmem_q[s][0] == 2'(m))
          head_match[m] = 1'b1;
      end
    end
  end

  always_comb begin
    push        = '0;
    wlast_err_d = '0;
    for (int m = 0; m < NUM_M; m++) begin
      state_d[m] = state_q[m];
      sel_d[m]   = sel_q[m];
      len_d[m]   = len_q[m];
      cnt_d[m]   = cnt_q[m];
      aw_block[m] = (state_q[m] != ST_IDLE);
      case (state_q[m])
        ST_IDLE: begin
          if (aw_hs[m]) begin
            sel_d[m]   = aw_sel[3*m +: 3];
            len_d[m]   = aw_len[LW*m +: LW];
            cnt_d[m]   = '0;
            push[m]    = 1'b1;
            state_d[m] = ST_PEND;
          end
        end
        ST_PEND: begin
          if (head_match[m]) state_d[m] = ST_DATA;
        end
        ST_DATA: begin
          if (beat[m]) begin
            wlast_err_d[m] = m_wlast[m] ^ at_last[m];
            if (at_last[m]) begin
              cnt_d[m]   = '0;
              state_d[m] = ST_IDLE;
            end else begin
              cnt_d[m] = cnt_q[m] + 1'b1;
            end
          end
        end
        default: state_d[m] = ST_IDLE;
      endcase
    end
  end

  // Pop shifts the FIFO down first, so a same-cycle push lands behind the survivors.
  always_comb begin
    q_overflow = 1'b0;
    for (int s = 0; s < NUM_S; s++) begin
      logic pop_s;
      pop_s = 1'b0;
      for (int m = 0; m < NUM_M; m++) begin
        if (last_beat[m] && sel_q[m] == 3'(s)) pop_s = 1'b1;
      end
      qmem_d[s] = qmem_q[s];
      qcnt_d[s] = qcnt_q[s];
      if (pop_s && qcnt_q[s] != '0) begin
        for (int i = 0; i < QDEPTH - 1; i++) qmem_d[s][i] = qmem_q[s][i+1];
        qmem_d[s][QDEPTH-1] = '0;
        qcnt_d[s] = qcnt_q[s] - 1'b1;
      end
      for (int m = 0; m < NUM_M; m++) begin
        if (push[m] && aw_sel[3*m +: 3] == 3'(s)) begin
          if (qcnt_d[s] < QFULL) begin
            qmem_d[s][qcnt_d[s]] = 2'(m);
            qcnt_d[s] = qcnt_d[s] + 1'b1;
          end else begin
            q_overflow = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < NUM_M; m++) begin
        state_q[m] <= ST_IDLE;
        sel_q[m]   <= '0;
        len_q[m]   <= '0;
        cnt_q[m]   <= '0;
      end
      wlast_err_q <= '0;
      for (int s = 0; s < NUM_S; s++) begin
        qcnt_q[s] <= '0;
        for (int i = 0; i < QDEPTH; i++) qmem_q[s][i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wlast_err_q <= wlast_err_d;
      qcnt_q      <= qcnt_d;
      qmem_q      <= qmem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !q_overflow);

endmodule

// File: tb/tb_w_channel_router.sv
// Directed bench for w_channel_router: a slave-side monitor pops an expected-beat
// scoreboard on every handshake, and the main sequence checks timing points.
module tb_w_channel_router;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  aw_hs;
  logic [8:0]  aw_sel;
  logic [11:0] aw_len;
  logic [31:0] m_wdata [3];
  logic [3:0]  m_wstrb [3];
  logic [2:0]  m_wlast, m_wvalid;
  wire  [2:0]  m_wready;
  wire  [31:0] s_wdata [7];
  wire  [3:0]  s_wstrb [7];
  wire  [6:0]  s_wvalid, s_wlast;
  logic [6:0]  s_wready;
  wire  [2:0]  aw_block, wlast_err;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  beat_t sb_q [7][$];

  w_channel_router dut (
    .clk(clk), .rst(rst),
    .aw_hs(aw_hs), .aw_sel(aw_sel), .aw_len(aw_len),
    .WDATA_M0(m_wdata[0]), .WSTRB_M0(m_wstrb[0]), .WLAST_M0(m_wlast[0]),
    .WVALID_M0(m_wvalid[0]), .WREADY_M0(m_wready[0]),
    .WDATA_M1(m_wdata[1]), .WSTRB_M1(m_wstrb[1]), .WLAST_M1(m_wlast[1]),
    .WVALID_M1(m_wvalid[1]), .WREADY_M1(m_wready[1]),
    .WDATA_M2(m_wdata[2]), .WSTRB_M2(m_wstrb[2]), .WLAST_M2(m_wlast[2]),
    .WVALID_M2(m_wvalid[2]), .WREADY_M2(m_wready[2]),
    .WDATA_SD(s_wdata[0]), .WSTRB_SD(s_wstrb[0]), .WLAST_SD(s_wlast[0]),
    .WVALID_SD(s_wvalid[0]), .WREADY_SD(s_wready[0]),
    .WDATA_S0(s_wdata[1]), .WSTRB_S0(s_wstrb[1]), .WLAST_S0(s_wlast[1]),
    .WVALID_S0(s_wvalid[1]), .WREADY_S0(s_wready[1]),
    .WDATA_S1(s_wdata[2]), .WSTRB_S1(s_wstrb[2]), .WLAST_S1(s_wlast[2]),
    .WVALID_S1(s_wvalid[2]), .WREADY_S1(s_wready[2]),
    .WDATA_S2(s_wdata[3]), .WSTRB_S2(s_wstrb[3]), .WLAST_S2(s_wlast[3]),
    .WVALID_S2(s_wvalid[3]), .WREADY_S2(s_wready[3]),
    .WDATA_S3(s_wdata[4]), .WSTRB_S3(s_wstrb[4]), .WLAST_S3(s_wlast[4]),
    .WVALID_S3(s_wvalid[4]), .WREADY_S3(s_wready[4]),
    .WDATA_S4(s_wdata[5]), .WSTRB_S4(s_wstrb[5]), .WLAST_S4(s_wlast[5]),
    .WVALID_S4(s_wvalid[5]), .WREADY_S4(s_wready[5]),
    .WDATA_S5(s_wdata[6]), .WSTRB_S5(s_wstrb[6]), .WLAST_S5(s_wlast[6]),
    .WVALID_S5(s_wvalid[6]), .WREADY_S5(s_wready[6]),
    .aw_block(aw_block), .wlast_err(wlast_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aw(input int m, input logic [2:0] sel, input logic [3:0] len);
    aw_hs[m] = 1'b1;
    aw_sel[3*m +: 3] = sel;
    aw_len[4*m +: 4] = len;
  endtask

  task automatic drive(input int m, input logic v, input logic [31:0] d,
                       input logic [3:0] st, input logic l);
    m_wvalid[m] = v;
    m_wdata[m]  = d;
    m_wstrb[m]  = st;
    m_wlast[m]  = l;
  endtask

  task automatic expect_beat(input int s, input logic [31:0] d, input logic [3:0] st,
                             input logic l);
    beat_t b;
    b.data = d;
    b.strb = st;
    b.last = l;
    sb_q[s].push_back(b);
  endtask

  // Slave-side monitor: every handshake must match the next expected beat.
  always @(negedge clk) begin
    if (rst) begin
      for (int s = 0; s < 7; s++) begin
        if (s_wvalid[s] && s_wready[s]) begin
          chk($sformatf("sb_nonempty_s%0d", s), 32'(sb_q[s].size() != 0), 32'd1);
          if (sb_q[s].size() != 0) begin
            beat_t b;
            b = sb_q[s].pop_front();
            chk($sformatf("sb_data_s%0d", s), s_wdata[s], b.data);
            chk($sformatf("sb_strb_s%0d", s), 32'(s_wstrb[s]), 32'(b.strb));
            chk($sformatf("sb_last_s%0d", s), 32'(s_wlast[s]), 32'(b.last));
          end
        end
      end
    end
  end

  initial begin
    aw_hs = '0; aw_sel = '0; aw_len = '0;
    for (int m = 0; m < 3; m++) drive(m, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1);
    s_wready = '1;

    // Reset state with masters and slaves all asserting
    #3;
    chk("rst_m_wready", 32'(m_wready), 32'd0);
    chk("rst_s_wvalid", 32'(s_wvalid), 32'd0);
    chk("rst_s_wlast", 32'(s_wlast), 32'd0);
    chk("rst_s_wdata_sd", s_wdata[0], 32'd0);
    chk("rst_s_wstrb_s5", 32'(s_wstrb[6]), 32'd0);
    chk("rst_aw_block", 32'(aw_block), 32'd0);
    chk("rst_wlast_err", 32'(wlast_err), 32'd0);
    for (int m = 0; m < 3; m++) drive(m, 1'b0, 32'd0, 4'd0, 1'b0);
    s_wready = '0;
    step();
    rst = 1'b1;
    step();

    // Single burst: M1 -> S1, len 3, beat presented before AW
    s_wready = 7'b0000100;
    set_aw(1, 3'd2, 4'd3);
    drive(1, 1'b1, 32'hA100_0000, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) expect_beat(2, 32'hA100_0000 + 32'(i), 4'hF, i == 3);
    @(negedge clk);
    chk("t1_blk_idle", 32'(aw_block), 32'd0);
    chk("t1_stall_idle", 32'(m_wready[1]), 32'd0);
    step();
    aw_hs = '0;
    @(negedge clk);
    chk("t1_blk_pend", 32'(aw_block), 32'b010);
    chk("t1_stall_pend", 32'(m_wready[1]), 32'd0);
    chk("t1_s1_quiet", 32'(s_wvalid[2]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_rdy", 32'(m_wready[1]), 32'd1);
      chk("t1_wlast_s1", 32'(s_wlast[2]), 32'(i == 3));
      chk("t1_blk_hold", 32'(aw_block[1]), 32'd1);
      step();
      if (i < 3) drive(1, 1'b1, 32'hA100_0000 + 32'(i + 1), 4'hF, (i + 1) == 3);
      else       drive(1, 1'b0, 32'd0, 4'd0, 1'b0);
    end
    @(negedge clk);
    chk("t1_blk_drop", 32'(aw_block[1]), 32'd0);
    chk("t1_err", 32'(wlast_err), 32'd0);
    step();

    // Ordering: M1 then M2 to S0, len 1 each
    s_wready = 7'b0000010;
    set_aw(1, 3'd1, 4'd1);
    drive(1, 1'b1, 32'hB100_0000, 4'h3, 1'b0);
    drive(2, 1'b1, 32'hB200_0000, 4'hC, 1'b0);
    expect_beat(1, 32'hB100_0000, 4'h3, 1'b0);
    expect_beat(1, 32'hB100_0001, 4'h3, 1'b1);
    step();
    aw_hs = '0;
    set_aw(2, 3'd1, 4'd1);
    expect_beat(1, 32'hB200_0000, 4'hC, 1'b0);
    expect_beat(1, 32'hB200_0001, 4'hC, 1'b1);
    @(negedge clk);
    chk("t2_m1_pend", 32'(m_wready[1]), 32'd0);
    chk("t2_m2_wait_a", 32'(m_wready[2]), 32'd0);
    step();
    aw_hs = '0;
    @(negedge clk);
    chk("t2_m1_data", 32'(m_wready[1]), 32'd1);
    chk("t2_m2_wait_b", 32'(m_wready[2]), 32'd0);
    step();
    drive(1, 1'b1, 32'hB100_0001, 4'h3, 1'b1);
    @(negedge clk);
    chk("t2_m2_wait_c", 32'(m_wready[2]), 32'd0);
    chk("t2_m1_wlast", 32'(s_wlast[1]), 32'd1);
    step();
    drive(1, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("t2_m2_gap", 32'(m_wready[2]), 32'd0);
    chk("t2_s0_gap", 32'(s_wvalid[1]), 32'd0);
    step();
    @(negedge clk);
    chk("t2_m2_data", 32'(m_wready[2]), 32'd1);
    chk("t2_m2_first", 32'(s_wlast[1]), 32'd0);
    step();
    drive(2, 1'b1, 32'hB200_0001, 4'hC, 1'b1);
    @(negedge clk);
    chk("t2_m2_wlast", 32'(s_wlast[1]), 32'd1);
    step();
    drive(2, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("t2_blk_clear", 32'(aw_block), 32'd0);
    step();

    // Concurrency: M1 -> SD and M2 -> S5 together, len 0
    s_wready = 7'b1000001;
    set_aw(1, 3'd0, 4'd0);
    set_aw(2, 3'd6, 4'd0);
    drive(1, 1'b1, 32'hC100_0000, 4'h3, 1'b1);
    drive(2, 1'b1, 32'hC200_0000, 4'hC, 1'b1);
    expect_beat(0, 32'hC100_0000, 4'h3, 1'b1);
    expect_beat(6, 32'hC200_0000, 4'hC, 1'b1);
    step();
    aw_hs = '0;
    @(negedge clk);
    chk("t3_pend_rdy", 32'(m_wready), 32'd0);
    step();
    @(negedge clk);
    chk("t3_both_rdy", 32'(m_wready), 32'b110);
    chk("t3_both_wlast", 32'(s_wlast), 32'b1000001);
    step();
    drive(1, 1'b0, 32'd0, 4'd0, 1'b0);
    drive(2, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("t3_blk_clear", 32'(aw_block), 32'd0);
    step();

    // Backpressure: M0 -> S3, len 1, WREADY_S3 toggles 1,0,1,0
    s_wready = 7'b0000000;
    set_aw(0, 3'd4, 4'd1);
    drive(0, 1'b1, 32'hD000_0000, 4'h1, 1'b0);
    expect_beat(4, 32'hD000_0000, 4'h1, 1'b0);
    expect_beat(4, 32'hD000_0001, 4'h2, 1'b1);
    step();
    aw_hs = '0;
    step();
    s_wready = 7'b0010000;
    @(negedge clk);
    chk("t4_rdy_a", 32'(m_wready[0]), 32'd1);
    step();
    s_wready = 7'b0000000;
    drive(0, 1'b1, 32'hD000_0001, 4'h2, 1'b1);
    @(negedge clk);
    chk("t4_stall_rdy", 32'(m_wready[0]), 32'd0);
    chk("t4_stall_valid", 32'(s_wvalid[4]), 32'd1);
    chk("t4_stall_data", s_wdata[4], 32'hD000_0001);
    chk("t4_stall_wlast", 32'(s_wlast[4]), 32'd1);
    step();
    s_wready = 7'b0010000;
    @(negedge clk);
    chk("t4_held_data", s_wdata[4], 32'hD000_0001);
    chk("t4_rdy_b", 32'(m_wready[0]), 32'd1);
    step();
    s_wready = 7'b0000000;
    drive(0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("t4_blk_drop", 32'(aw_block[0]), 32'd0);
    chk("t4_s3_idle", 32'(s_wvalid[4]), 32'd0);
    step();

    // WLAST mismatch: M0 -> S2, len 2, master flags last on beat 2
    s_wready = 7'b0001000;
    set_aw(0, 3'd3, 4'd2);
    drive(0, 1'b1, 32'hE000_0000, 4'h7, 1'b0);
    expect_beat(3, 32'hE000_0000, 4'h7, 1'b0);
    expect_beat(3, 32'hE000_0001, 4'h7, 1'b0);
    expect_beat(3, 32'hE000_0002, 4'h7, 1'b1);
    step();
    aw_hs = '0;
    step();
    @(negedge clk);
    chk("t5_err_b0", 32'(wlast_err), 32'd0);
    chk("t5_wlast_b0", 32'(s_wlast[3]), 32'd0);
    step();
    drive(0, 1'b1, 32'hE000_0001, 4'h7, 1'b1);
    @(negedge clk);
    chk("t5_err_b1", 32'(wlast_err), 32'd0);
    chk("t5_wlast_b1", 32'(s_wlast[3]), 32'd0);
    step();
    drive(0, 1'b1, 32'hE000_0002, 4'h7, 1'b1);
    @(negedge clk);
    chk("t5_err_pulse", 32'(wlast_err), 32'b001);
    chk("t5_wlast_b2", 32'(s_wlast[3]), 32'd1);
    chk("t5_continue", 32'(m_wready[0]), 32'd1);
    step();
    drive(0, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("t5_err_clear", 32'(wlast_err), 32'd0);
    chk("t5_blk_clear", 32'(aw_block), 32'd0);
    step();

    // Reset mid-burst: M2 -> S4, len 3, reset after first beat
    s_wready = 7'b0100000;
    set_aw(2, 3'd5, 4'd3);
    drive(2, 1'b1, 32'hF000_0000, 4'hA, 1'b0);
    expect_beat(5, 32'hF000_0000, 4'hA, 1'b0);
    step();
    aw_hs = '0;
    step();
    @(negedge clk);
    chk("t6_rdy", 32'(m_wready[2]), 32'd1);
    step();
    drive(2, 1'b1, 32'hF000_0001, 4'hA, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_rdy", 32'(m_wready), 32'd0);
    chk("t6_rst_valid", 32'(s_wvalid), 32'd0);
    chk("t6_rst_wlast", 32'(s_wlast), 32'd0);
    chk("t6_rst_data", s_wdata[5], 32'd0);
    chk("t6_rst_blk", 32'(aw_block), 32'd0);
    chk("t6_rst_err", 32'(wlast_err), 32'd0);
    step();
    drive(2, 1'b0, 32'd0, 4'd0, 1'b0);
    step();
    rst = 1'b1;
    step();
    set_aw(2, 3'd5, 4'd1);
    drive(2, 1'b1, 32'hF100_0000, 4'h5, 1'b0);
    expect_beat(5, 32'hF100_0000, 4'h5, 1'b0);
    expect_beat(5, 32'hF100_0001, 4'h5, 1'b1);
    step();
    aw_hs = '0;
    step();
    @(negedge clk);
    chk("t6_new_rdy", 32'(m_wready[2]), 32'd1);
    chk("t6_cnt_zero", 32'(s_wlast[5]), 32'd0);
    step();
    drive(2, 1'b1, 32'hF100_0001, 4'h5, 1'b1);
    @(negedge clk);
    chk("t6_new_wlast", 32'(s_wlast[5]), 32'd1);
    step();
    drive(2, 1'b0, 32'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("t6_blk_clear", 32'(aw_block), 32'd0);
    step();

    for (int s = 0; s < 7; s++)
      chk($sformatf("sb_drained_s%0d", s), 32'(sb_q[s].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/w_channel_router.md
Name: w_channel_router

Overview:
- Write-data (W) stage of the AXI interconnect. It sits directly downstream of the write-address (AW) arbitration stage.
- Each accepted AW handshake is recorded as a route (master, target slave, burst length).
- W beats from 3 masters are steered to 7 slaves (SD, S0..S5) in per-slave AW-acceptance order. The block counts beats, generates WLAST toward the slave, and back-pressures masters and the AW stage.

Parameters:
NUM_M, 3, number of masters (IDs 0..2)
NUM_S, 7, number of slaves (index 0=SD, 1..6=S0..S5)
QDEPTH, 3, per-slave route-queue depth (= NUM_M)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
aw_hs  in  3  bit m = AW handshake of master m this cycle (AWVALID_Mm & AWREADY_Mm)
aw_sel  in  9  3-bit target slave index per master; master m at [3m+2:3m]
aw_len  in  12  `AXI_LEN_BITS (4) per master; master m at [4m+3:4m]
WDATA_Mm (m=0..2)  in  `AXI_DATA_BITS  master write data
WSTRB_Mm  in  `AXI_STRB_BITS  master byte strobes
WLAST_Mm  in  1  master last-beat flag
WVALID_Mm  in  1  master beat valid
WREADY_Mm  out  1  beat accepted by routed slave
WDATA_Sx (x=D,0..5)  out  `AXI_DATA_BITS  slave write data
WSTRB_Sx  out  `AXI_STRB_BITS  slave strobes
WLAST_Sx  out  1  last beat, generated from the beat counter
WVALID_Sx  out  1  slave beat valid
WREADY_Sx  in  1  slave ready
aw_block  out  3  bit m=1: master m has an outstanding write; the AW stage must hold AWREADY_Mm low
wlast_err  out  3  one-cycle pulse: master WLAST disagreed with the counted last beat

Behaviour:
Reset (rst=0, asynchronous):
- All queues empty; all per-master states IDLE; counters 0.
- All WREADY_M, WVALID_S, WLAST_S, WDATA_S, WSTRB_S, aw_block, wlast_err are 0.
- Reset mid-burst abandons the burst; no beats are replayed.

Per-master FSM (registered):
- IDLE: on aw_hs[m], latch sel=aw_sel[m], len=aw_len[m], cnt=0; push m onto queue[sel]; go to PEND.
- PEND: advance to DATA on the cycle queue[sel] head equals m. This is evaluated on registered queue state, so it takes effect the cycle after head changes.
- DATA: master routed to slave sel.
- aw_hs[m] while not IDLE is ignored; no push.
- aw_block[m] = (state != IDLE), registered. It asserts the cycle after aw_hs.

Routing and latency:
- Routing is combinational while master m is in DATA: WVALID_Ssel=WVALID_Mm, WDATA/WSTRB pass through, WREADY_Mm=WREADY_Ssel.
- A slave with no DATA owner drives WVALID=0, WLAST=0, WDATA=0, WSTRB=0.
- A master not in DATA sees WREADY=0. W beats presented before the AW handshake are stalled, not dropped.
- Minimum latency: aw_hs at edge t with an empty queue gives PEND at t+1 and DATA at t+2. The first beat can transfer in the cycle following edge t+2.

Beat counting:
- Beat handshake = WVALID_Mm & WREADY_Mm in DATA.
- cnt increments per beat, width 4 bits. The burst has len+1 beats (1..16); cnt never wraps within a burst.
- WLAST_Ssel = (cnt==len) while in DATA, independent of WLAST_Mm.
- On every beat, if WLAST_Mm != (cnt==len), pulse wlast_err[m] the next cycle. The counted length still governs termination.
- On the beat with cnt==len: pop queue[sel], cnt=0, go to IDLE. aw_block[m] drops the following cycle.

Per-slave queue:
- FIFO of 2-bit master IDs, depth QDEPTH.
- Simultaneous push and pop in one cycle is legal; a single-entry queue then holds the new entry.
- Multiple pushes to the same slave in one cycle cannot occur because the AW stage serializes per slave. If it does occur, lowest master index is pushed first.
- Overflow is impossible with one outstanding write per master. Push-when-full is a design-assertion failure.
- Different slaves operate fully concurrently.

Test Plan:
- Single burst: M1 aw_hs, sel=2 (S1), len=3; 4 beats with WREADY_S1=1 -> beats on S1 at 4 consecutive cycles; WLAST_S1 on the 4th only; aw_block[1] high until the cycle after the last beat; wlast_err=0.
- Ordering: M1 then M2 AW to S0 (sel=1) on consecutive cycles, len=1 each -> M2 WREADY=0 until M1's 2nd beat completes; M2 enters DATA 1 cycle later; S0 sees M1,M1,M2,M2.
- Concurrency: M1 to SD (sel=0), M2 to S5 (sel=6) same cycle, len=0 -> both single beats transfer in the same cycle with WLAST on both slaves.
- Backpressure: WREADY_S3 toggling 1,0,1,0 for len=1 -> no beat duplicated or lost; data held stable while stalled.
- WLAST mismatch: len=2, master asserts WLAST on beat 2 -> wlast_err pulse; burst continues to 3 beats; WLAST_S on beat 3 only.
- Reset mid-burst: rst low after beat 1 of len=3 -> all outputs 0 immediately; after release, a new AW routes normally with cnt=0.
